// File: rtl/alu_wide_seq_if.sv
// ============================================================================
// Module      : alu_wide_seq_if
// Description : Request, response and byte-ALU channel bundle for alu_wide_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_wide_seq_if #(
    parameter int NBYTES = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic [8*NBYTES-1:0]   req_a;
    logic [8*NBYTES-1:0]   req_b;
    logic [3:0]            req_op;
    logic                  req_mode;
    logic                  req_cf;

    logic [7:0]            alu_a;
    logic [7:0]            alu_b;
    logic                  alu_cf_in;
    logic [3:0]            alu_op;
    logic                  alu_mode;
    logic [7:0]            alu_result;
    logic                  alu_cf;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [8*NBYTES-1:0]   rsp_data;
    logic                  rsp_cf;
    logic                  rsp_zf;
    logic                  rsp_sf;

    // Sequencer side
    modport slave (
        input  req_valid, req_a, req_b, req_op, req_mode, req_cf,
        output req_ready,
        output alu_a, alu_b, alu_cf_in, alu_op, alu_mode,
        input  alu_result, alu_cf,
        output rsp_valid, rsp_data, rsp_cf, rsp_zf, rsp_sf,
        input  rsp_ready
    );

    // Environment side: requester, response consumer and the byte ALU
    modport master (
        output req_valid, req_a, req_b, req_op, req_mode, req_cf,
        input  req_ready,
        input  alu_a, alu_b, alu_cf_in, alu_op, alu_mode,
        output alu_result, alu_cf,
        input  rsp_valid, rsp_data, rsp_cf, rsp_zf, rsp_sf,
        output rsp_ready
    );
endinterface

`default_nettype wire

// File: rtl/alu_wide_seq.sv
// ============================================================================
// Module      : alu_wide_seq
// Description : Runs one multi-byte operation through an 8-bit ALU, LSB first,
//               chaining carry/borrow, and returns the wide result with flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_wide_seq #(
    parameter int NBYTES = 2
) (
    input  wire           clk,
    input  wire           rst,
    alu_wide_seq_if.slave bus
);
    localparam int                c_W    = 8 * NBYTES;
    localparam int                c_IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BYTE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_W-1:0]     r_a;
    logic [c_W-1:0]     r_b;
    logic [c_W-1:0]     r_acc;
    logic [c_IDXW-1:0]  r_idx;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [c_W-1:0]     r_rsp_data;
    logic               r_rsp_cf;
    logic               r_rsp_zf;
    logic               r_rsp_sf;
    logic [7:0]         r_alu_a;
    logic [7:0]         r_alu_b;
    logic               r_alu_cf_in;
    logic [3:0]         r_alu_op;
    logic               r_alu_mode;

    logic [c_IDXW-1:0]  w_nidx;
    logic [c_W-1:0]     w_acc;

    // Next index saturates so the part-select below never leaves the operand.
    always_comb begin
        w_nidx = (r_idx == c_LAST) ? r_idx : r_idx + 1'b1;
        w_acc  = r_acc;
        w_acc[8*r_idx +: 8] = bus.alu_result;
    end

    // ALU drive registers are loaded one cycle ahead of the byte they serve;
    // r_alu_mode doubles as the captured mode for the whole operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_cf    <= 1'b0;
            r_rsp_zf    <= 1'b0;
            r_rsp_sf    <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_cf_in <= 1'b0;
            r_alu_op    <= '0;
            r_alu_mode  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_a         <= bus.req_a;
                        r_b         <= bus.req_b;
                        r_idx       <= '0;
                        r_alu_a     <= bus.req_a[7:0];
                        r_alu_b     <= bus.req_b[7:0];
                        r_alu_cf_in <= bus.req_cf & ~bus.req_mode;
                        r_alu_op    <= bus.req_op;
                        r_alu_mode  <= bus.req_mode;
                        r_req_ready <= 1'b0;
                        r_state     <= S_BYTE;
                    end
                end
                S_BYTE: begin
                    r_acc <= w_acc;
                    if (r_idx == c_LAST) begin
                        r_rsp_data  <= w_acc;
                        r_rsp_cf    <= bus.alu_cf & ~r_alu_mode;
                        r_rsp_zf    <= (w_acc == '0);
                        r_rsp_sf    <= w_acc[c_W-1];
                        r_rsp_valid <= 1'b1;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        r_alu_cf_in <= 1'b0;
                        r_alu_op    <= '0;
                        r_alu_mode  <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx       <= w_nidx;
                        r_alu_a     <= r_a[8*w_nidx +: 8];
                        r_alu_b     <= r_b[8*w_nidx +: 8];
                        r_alu_cf_in <= bus.alu_cf & ~r_alu_mode;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_cf    = r_rsp_cf;
    assign bus.rsp_zf    = r_rsp_zf;
    assign bus.rsp_sf    = r_rsp_sf;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_cf_in = r_alu_cf_in;
    assign bus.alu_op    = r_alu_op;
    assign bus.alu_mode  = r_alu_mode;
endmodule

`default_nettype wire
